// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: shares the machine-mode CSR file port between the
// core's Zicsr path and debug-module abstract commands. Core accesses pass
// straight through in one cycle; a debug access is a read cycle followed by
// an optional write cycle, and a starvation counter guarantees debug a slot.
//
// Debug handshake: DbgReq is a level request that carries DbgAdr/DbgOp/
// DbgWData. The command is latched in the grant cycle; later changes to those
// inputs are ignored. DbgDone pulses for exactly one cycle with DbgErr and
// DbgRData valid alongside it. A request is never granted while DbgDone is
// high, so the requester may drop DbgReq or present a new command in the
// following cycle. A machine trap during RD or WR aborts silently and the
// still-pending request is re-arbitrated from IDLE.
module csr_access_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            CoreReqM,
    input  logic [11:0]     CoreAdrM,
    input  logic            CoreWriteM,
    input  logic [XLEN-1:0] CoreWDataM,
    output logic            CoreStallM,
    input  logic            DbgReq,
    input  logic [11:0]     DbgAdr,
    input  logic [1:0]      DbgOp,
    input  logic [XLEN-1:0] DbgWData,
    output logic            DbgDone,
    output logic            DbgErr,
    output logic [XLEN-1:0] DbgRData,
    output logic [11:0]     CSRAdrM,
    output logic [XLEN-1:0] CSRWriteValM,
    output logic            CSRMWriteM,
    input  logic [XLEN-1:0] CSRMReadValM,
    input  logic            IllegalCSRMAccessM,
    input  logic            MTrapM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    state_t          state_q, state_d;
    logic [7:0]      count_q, count_d;
    logic [11:0]     adr_q, adr_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;

    logic            dbg_pending;
    logic            ro_fault;

    assign DbgDone  = done_q;
    assign DbgErr   = err_q;
    assign DbgRData = dbg_rdata_q;

    // Next-state, grant and CSR port steering for the IDLE/RD/WR sequencer.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        adr_d        = adr_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        CSRAdrM      = '0;
        CSRWriteValM = '0;
        CSRMWriteM   = 1'b0;
        CoreStallM   = 1'b0;
        dbg_pending  = DbgReq & ~done_q;
        // Writes, sets and clears to the 0xC00-0xFFF block are read-only faults.
        ro_fault     = (op_q != OP_READ) && (adr_q[11:10] == 2'b11);

        case (state_q)
            IDLE: begin
                if (dbg_pending && (!CoreReqM || count_q == LIMIT)) begin
                    adr_d      = DbgAdr;
                    op_d       = DbgOp;
                    wdata_d    = DbgWData;
                    count_d    = '0;
                    state_d    = RD;
                    CoreStallM = CoreReqM;
                end else if (CoreReqM) begin
                    CSRAdrM      = CoreAdrM;
                    CSRWriteValM = CoreWDataM;
                    CSRMWriteM   = CoreWriteM;
                    if (dbg_pending && count_q != LIMIT) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            RD: begin
                CSRAdrM    = adr_q;
                CoreStallM = CoreReqM;
                rdata_d    = CSRMReadValM;
                if (MTrapM) begin
                    state_d = IDLE;
                end else if (IllegalCSRMAccessM || ro_fault) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    dbg_rdata_d = '0;
                end else if (op_q == OP_READ) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    dbg_rdata_d = CSRMReadValM;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                CSRAdrM    = adr_q;
                CoreStallM = CoreReqM;
                CSRMWriteM = ~MTrapM;
                case (op_q)
                    OP_SET:   CSRWriteValM = rdata_q | wdata_q;
                    OP_CLEAR: CSRWriteValM = rdata_q & ~wdata_q;
                    OP_WRITE: CSRWriteValM = wdata_q;
                    default:  CSRWriteValM = wdata_q;
                endcase
                state_d = IDLE;
                if (!MTrapM) begin
                    done_d      = 1'b1;
                    dbg_rdata_d = rdata_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, starvation counter, latched command and registered debug outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            adr_q       <= '0;
            op_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            adr_q       <= adr_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule
